// File: rtl/eth_10g_mac_pause_tx_scheduler_if.sv
// Pause-length word stream from the scheduler to the TX pause timing adapter.
// Transfer happens on a rising clk edge when out_valid && out_ready.
interface eth_10g_mac_pause_tx_scheduler_if #(
    parameter int QUANTA_W = 16
);
    logic                out_valid;
    logic [QUANTA_W-1:0] out_data;
    logic                out_ready;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/eth_10g_mac_pause_tx_scheduler.sv
// XOFF/XON/software pause-quanta sequencer for the 10G MAC pause TX path.
// Optional statistics counters are built when ETH_10G_PAUSE_SCHED_STATS_EN is defined.
module eth_10g_mac_pause_tx_scheduler #(
    parameter int QUANTA_W  = 16,
    parameter int REFRESH_W = 24,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [QUANTA_W-1:0]  cfg_xoff_quanta,
    input  logic [REFRESH_W-1:0] cfg_refresh_period,
    input  logic                 xoff_req,
    input  logic                 sw_req,
    input  logic [QUANTA_W-1:0]  sw_quanta,
    eth_10g_mac_pause_tx_scheduler_if.master pause_tx,
    output logic                 pause_active,
    output logic                 sw_pending,
    output logic [CNT_W-1:0]     stat_xoff_cnt,
    output logic [CNT_W-1:0]     stat_xon_cnt,
    output logic [2:0]           state_dbg
);

    // Handshake: a word moves on a rising edge with out_valid && out_ready; once raised,
    // out_valid and out_data stay put until that edge.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_XOFF = 3'd1,
        S_WAIT = 3'd2,
        S_XON  = 3'd3,
        S_SW   = 3'd4
    } state_t;

    state_t               state, state_nxt;
    logic                 out_valid_q, out_valid_nxt;
    logic [QUANTA_W-1:0]  out_data_q, out_data_nxt;
    logic                 pause_q, pause_nxt;
    logic                 sw_pend_q, sw_pend_nxt;
    logic [QUANTA_W-1:0]  sw_quanta_q, sw_quanta_nxt;
    logic [REFRESH_W-1:0] refresh_cnt, refresh_cnt_nxt;
    logic                 xfer;

    assign xfer = out_valid_q && pause_tx.out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (xoff_req) begin
                    state_nxt = S_XOFF;
                end else if (sw_pend_q) begin
                    state_nxt = S_SW;
                end
            end
            S_XOFF: if (xfer) state_nxt = S_WAIT;
            // Falling xoff_req beats refresh expiry so the partner is released promptly.
            S_WAIT: begin
                if (!xoff_req) begin
                    state_nxt = S_XON;
                end else if ((cfg_refresh_period != '0) && (refresh_cnt == REFRESH_W'(1))) begin
                    state_nxt = S_XOFF;
                end
            end
            S_XON:  if (xfer) state_nxt = S_IDLE;
            S_SW:   if (xfer) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid_nxt   = out_valid_q;
        out_data_nxt    = out_data_q;
        pause_nxt       = pause_q;
        sw_pend_nxt     = sw_pend_q;
        sw_quanta_nxt   = sw_quanta_q;
        refresh_cnt_nxt = refresh_cnt;

        if (xfer) out_valid_nxt = 1'b0;

        // Each entry into a word-sending state loads the word for the following cycle.
        if (state_nxt != state) begin
            unique case (state_nxt)
                S_XOFF: begin
                    out_valid_nxt = 1'b1;
                    out_data_nxt  = cfg_xoff_quanta;
                end
                S_XON: begin
                    out_valid_nxt = 1'b1;
                    out_data_nxt  = '0;
                end
                S_SW: begin
                    out_valid_nxt = 1'b1;
                    out_data_nxt  = sw_quanta_q;
                end
                default: ;
            endcase
        end

        if (state == S_XOFF && xfer) begin
            pause_nxt       = 1'b1;
            refresh_cnt_nxt = cfg_refresh_period;
        end else if (state == S_WAIT && state_nxt == S_WAIT && refresh_cnt != '0) begin
            refresh_cnt_nxt = refresh_cnt - REFRESH_W'(1);
        end

        if (state == S_XON && xfer) pause_nxt = 1'b0;

        // A fresh request in the same cycle as the sw word leaves keeps the pending flag.
        if (sw_req) begin
            sw_pend_nxt   = 1'b1;
            sw_quanta_nxt = sw_quanta;
        end else if (state == S_SW && xfer) begin
            sw_pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            pause_q     <= 1'b0;
            sw_pend_q   <= 1'b0;
            sw_quanta_q <= '0;
            refresh_cnt <= '0;
        end else begin
            out_valid_q <= out_valid_nxt;
            out_data_q  <= out_data_nxt;
            pause_q     <= pause_nxt;
            sw_pend_q   <= sw_pend_nxt;
            sw_quanta_q <= sw_quanta_nxt;
            refresh_cnt <= refresh_cnt_nxt;
        end
    end

`ifdef ETH_10G_PAUSE_SCHED_STATS_EN
    logic [CNT_W-1:0] xoff_cnt_q, xon_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xoff_cnt_q <= '0;
            xon_cnt_q  <= '0;
        end else begin
            if (state == S_XOFF && xfer) xoff_cnt_q <= xoff_cnt_q + CNT_W'(1);
            if (state == S_XON && xfer)  xon_cnt_q  <= xon_cnt_q + CNT_W'(1);
        end
    end

    assign stat_xoff_cnt = xoff_cnt_q;
    assign stat_xon_cnt  = xon_cnt_q;
`else
    assign stat_xoff_cnt = '0;
    assign stat_xon_cnt  = '0;
`endif

    assign pause_tx.out_valid = out_valid_q;
    assign pause_tx.out_data  = out_data_q;
    assign pause_active       = pause_q;
    assign sw_pending         = sw_pend_q;
    assign state_dbg          = state;

endmodule

// File: tb/tb_eth_10g_mac_pause_tx_scheduler.sv
// Directed scoreboard bench for eth_10g_mac_pause_tx_scheduler: every accepted word is popped
// from an expected queue; holds, refresh spacing, sw merging and async reset are checked.
module tb_eth_10g_mac_pause_tx_scheduler;
    localparam int QUANTA_W  = 16;
    localparam int REFRESH_W = 24;
    localparam int CNT_W     = 32;
`ifdef ETH_10G_PAUSE_SCHED_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [QUANTA_W-1:0]  cfg_xoff_quanta;
    logic [REFRESH_W-1:0] cfg_refresh_period;
    logic                 xoff_req;
    logic                 sw_req;
    logic [QUANTA_W-1:0]  sw_quanta;
    logic                 pause_active;
    logic                 sw_pending;
    logic [CNT_W-1:0]     stat_xoff_cnt;
    logic [CNT_W-1:0]     stat_xon_cnt;
    logic [2:0]           state_dbg;

    eth_10g_mac_pause_tx_scheduler_if #(.QUANTA_W(QUANTA_W)) pause_if ();

    eth_10g_mac_pause_tx_scheduler #(
        .QUANTA_W(QUANTA_W), .REFRESH_W(REFRESH_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cfg_xoff_quanta(cfg_xoff_quanta),
        .cfg_refresh_period(cfg_refresh_period),
        .xoff_req(xoff_req),
        .sw_req(sw_req),
        .sw_quanta(sw_quanta),
        .pause_tx(pause_if),
        .pause_active(pause_active),
        .sw_pending(sw_pending),
        .stat_xoff_cnt(stat_xoff_cnt),
        .stat_xon_cnt(stat_xon_cnt),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    logic [QUANTA_W-1:0] exp_q[$];
    int                  xoff_cyc_q[$];
    int                  total = 0;
    int                  bad = 0;
    int                  cyc = 0;
    logic                hold_prev = 1'b0;
    logic [QUANTA_W-1:0] hold_data = '0;
    logic [CNT_W-1:0]    exp_xoff_n = '0;
    logic [CNT_W-1:0]    exp_xon_n = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard and hold checks on the falling edge, return just after the rising edge.
    task automatic cycle();
        logic [QUANTA_W-1:0] exp_w;
        @(negedge clk);
        cyc++;
        if (hold_prev) begin
            chk("hold_valid", 64'(pause_if.out_valid), 64'd1);
            chk("hold_data", 64'(pause_if.out_data), 64'(hold_data));
        end
        if (pause_if.out_valid && pause_if.out_ready) begin
            if (pause_if.out_data != '0) xoff_cyc_q.push_back(cyc);
            chk("word_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                chk("word_data", 64'(pause_if.out_data), 64'(exp_w));
            end
        end
        hold_prev = pause_if.out_valid && !pause_if.out_ready;
        hold_data = pause_if.out_data;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic sw_pulse(input logic [QUANTA_W-1:0] q);
        sw_req    = 1'b1;
        sw_quanta = q;
        cycle();
        sw_req    = 1'b0;
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "_xoff"}, 64'(stat_xoff_cnt), STATS_EN ? 64'(exp_xoff_n) : 64'd0);
        chk({tag, "_xon"}, 64'(stat_xon_cnt), STATS_EN ? 64'(exp_xon_n) : 64'd0);
    endtask

    initial begin
        reset_n            = 1'b0;
        cfg_xoff_quanta    = '0;
        cfg_refresh_period = '0;
        xoff_req           = 1'b0;
        sw_req             = 1'b0;
        sw_quanta          = '0;
        pause_if.out_ready = 1'b1;
        run(3);
        reset_n = 1'b1;

        // 1: idle after reset
        chk("rst_state", 64'(state_dbg), 64'd0);
        chk("rst_sw_pending", 64'(sw_pending), 64'd0);
        chk_stats("rst_stat");
        for (int i = 0; i < 100; i++) begin
            cycle();
            chk("idle_out", 64'({pause_if.out_valid, pause_if.out_data, pause_active}), 64'd0);
        end

        // 2: single XOFF then XON, refresh disabled
        cfg_xoff_quanta = 16'hFFFF;
        xoff_req = 1'b1;
        exp_q.push_back(16'hFFFF);
        run(10);
        chk("t2_pause_mid", 64'(pause_active), 64'd1);
        run(40);
        xoff_req = 1'b0;
        exp_q.push_back(16'h0000);
        drain(20);
        exp_xoff_n++;
        exp_xon_n++;
        chk("t2_pause_end", 64'(pause_active), 64'd0);
        chk_stats("t2_stat");

        // 3: refresh every 100 cycles while held for 350
        cfg_refresh_period = 24'd100;
        cfg_xoff_quanta = 16'h1234;
        xoff_cyc_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(16'h1234);
        xoff_req = 1'b1;
        run(350);
        xoff_req = 1'b0;
        exp_q.push_back(16'h0000);
        drain(20);
        exp_xoff_n += 4;
        exp_xon_n++;
        chk("t3_xoff_words", 64'(xoff_cyc_q.size()), 64'd4);
        // next valid rises 100 edges after acceptance; with ready high it is sampled one cycle later
        if (xoff_cyc_q.size() == 4) begin
            for (int i = 1; i < 4; i++)
                chk("t3_refresh_gap", 64'(xoff_cyc_q[i] - xoff_cyc_q[i-1]), 64'd101);
        end
        chk_stats("t3_stat");
        cfg_refresh_period = '0;

        // 4: backpressure during XOFF, request dropped mid-stall
        cfg_xoff_quanta = 16'h00FF;
        pause_if.out_ready = 1'b0;
        xoff_req = 1'b1;
        exp_q.push_back(16'h00FF);
        run(2);
        chk("t4_valid", 64'(pause_if.out_valid), 64'd1);
        chk("t4_data", 64'(pause_if.out_data), 64'h00FF);
        run(3);
        xoff_req = 1'b0;
        exp_q.push_back(16'h0000);
        run(15);
        pause_if.out_ready = 1'b1;
        drain(10);
        exp_xoff_n++;
        exp_xon_n++;
        chk("t4_pause_end", 64'(pause_active), 64'd0);
        chk_stats("t4_stat");

        // 5: two sw requests while XOFF held; only the last quanta goes out after XON
        cfg_xoff_quanta = 16'h1111;
        xoff_req = 1'b1;
        exp_q.push_back(16'h1111);
        run(5);
        sw_pulse(16'h0010);
        sw_pulse(16'h0020);
        run(5);
        chk("t5_sw_pending", 64'(sw_pending), 64'd1);
        chk("t5_pause", 64'(pause_active), 64'd1);
        xoff_req = 1'b0;
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0020);
        drain(20);
        exp_xoff_n++;
        exp_xon_n++;
        run(5);
        chk("t5_sw_cleared", 64'(sw_pending), 64'd0);
        chk("t5_pause_end", 64'(pause_active), 64'd0);
        chk_stats("t5_stat");

        // sw request of zero quanta goes out as-is and leaves pause state alone
        exp_q.push_back(16'h0000);
        sw_pulse(16'h0000);
        drain(10);
        run(3);
        chk("sw0_pause", 64'(pause_active), 64'd0);
        chk("sw0_pending", 64'(sw_pending), 64'd0);
        chk_stats("sw0_stat");

        // 6: async reset while a word is stalled
        cfg_xoff_quanta = 16'hABCD;
        pause_if.out_ready = 1'b0;
        xoff_req = 1'b1;
        run(3);
        chk("t6_valid_pre", 64'(pause_if.out_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_out", 64'({pause_if.out_valid, pause_if.out_data}), 64'd0);
        chk("t6_rst_flags", 64'({pause_active, sw_pending}), 64'd0);
        chk("t6_rst_state", 64'(state_dbg), 64'd0);
        exp_xoff_n = '0;
        exp_xon_n = '0;
        chk_stats("t6_rst_stat");
        hold_prev = 1'b0;
        exp_q.delete();
        xoff_req = 1'b0;
        pause_if.out_ready = 1'b1;
        run(3);
        reset_n = 1'b1;
        run(20);
        chk("t6_no_replay", 64'(pause_if.out_valid), 64'd0);
        chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
